// File: rtl/if_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// if_fetch_sequencer
//
// Runs instruction fetches for the IF stage over the shared memory bus. It
// takes a word address from the PC logic and performs the request / grant /
// ready handshake with the bus arbiter. The fetched instruction is returned
// through a registered output with a one-cycle valid strobe. The block also
// produces the stall signal for the IF/ID pipeline register.
//
// If a flush arrives while an access is outstanding, the bus transaction still
// completes, but its data is discarded. If the bus does not assert ready within
// TIMEOUT cycles after the grant, the access is abandoned. In that case a NOP
// is delivered and bus_err is pulsed. If the access was flushed, no NOP is
// delivered and only bus_err is pulsed.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   fetch_en            PC logic requests a fetch of fetch_addr
//   fetch_addr          word address, sampled only when a fetch starts
//   flush               pipeline flush; the current fetch is not delivered
//   bus_req, bus_addr   request and latched address towards the arbiter
//   bus_gnt             arbiter grant
//   bus_rdy, bus_rd_data  read data valid strobe and read data
//   insn, insn_valid    registered instruction and its one-cycle strobe
//   fetch_busy          combinational stall into the IF/ID register
//   bus_err             one-cycle pulse on bus timeout
// ---------------------------------------------------------------------------
module if_fetch_sequencer #(
  parameter int unsigned         ADDR_W   = 30,
  parameter int unsigned         DATA_W   = 32,
  parameter int unsigned         TIMEOUT  = 255,
  parameter logic [DATA_W-1:0]   NOP_INSN = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              flush,
  output logic              bus_req,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_gnt,
  input  logic              bus_rdy,
  input  logic [DATA_W-1:0] bus_rd_data,
  output logic [DATA_W-1:0] insn,
  output logic              insn_valid,
  output logic              fetch_busy,
  output logic              bus_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACCESS,
    DISCARD
  } state_t;

  state_t            state_q, state_d;
  logic              bus_req_q, bus_req_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] insn_q, insn_d;
  logic              insn_valid_q, insn_valid_d;
  logic              bus_err_q, bus_err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeout_hit;

  // The wait counter starts at zero on the grant, so this match occurs in the
  // TIMEOUT-th cycle after the grant.
  assign timeout_hit = (cnt_q == CNT_LAST);

  always_comb begin
    state_d      = state_q;
    bus_req_d    = bus_req_q;
    bus_addr_d   = bus_addr_q;
    insn_d       = insn_q;
    insn_valid_d = 1'b0;
    bus_err_d    = 1'b0;
    cnt_d        = cnt_q;

    unique case (state_q)
      IDLE: begin
        // While insn_valid is high, the consumer is still advancing the PC,
        // so we hold off for one cycle before starting the next fetch.
        if (fetch_en && !insn_valid_q && !flush) begin
          bus_addr_d = fetch_addr;
          bus_req_d  = 1'b1;
          state_d    = REQ;
        end
      end

      REQ: begin
        if (bus_gnt) begin
          cnt_d   = '0;
          state_d = flush ? DISCARD : ACCESS;
        end else if (flush) begin
          bus_req_d = 1'b0;
          state_d   = IDLE;
        end
      end

      ACCESS: begin
        if (bus_rdy) begin
          bus_req_d = 1'b0;
          state_d   = IDLE;
          if (!flush) begin
            insn_d       = bus_rd_data;
            insn_valid_d = 1'b1;
          end
        end else if (timeout_hit) begin
          // A timeout takes priority over a flush in the same cycle: the
          // access is terminated either way. The flush only suppresses
          // delivery of the substituted NOP.
          bus_req_d = 1'b0;
          bus_err_d = 1'b1;
          state_d   = IDLE;
          if (!flush) begin
            insn_d       = NOP_INSN;
            insn_valid_d = 1'b1;
          end
        end else begin
          // The counter keeps running across the move to DISCARD, so the
          // timeout deadline is unaffected by the flush.
          cnt_d = cnt_q + CNT_W'(1);
          if (flush) begin
            state_d = DISCARD;
          end
        end
      end

      DISCARD: begin
        if (bus_rdy) begin
          bus_req_d = 1'b0;
          state_d   = IDLE;
        end else if (timeout_hit) begin
          bus_req_d = 1'b0;
          bus_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d   = IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      bus_req_q    <= 1'b0;
      bus_addr_q   <= '0;
      insn_q       <= NOP_INSN;
      insn_valid_q <= 1'b0;
      bus_err_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      bus_req_q    <= bus_req_d;
      bus_addr_q   <= bus_addr_d;
      insn_q       <= insn_d;
      insn_valid_q <= insn_valid_d;
      bus_err_q    <= bus_err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus_req    = bus_req_q;
  assign bus_addr   = bus_addr_q;
  assign insn       = insn_q;
  assign insn_valid = insn_valid_q;
  assign bus_err    = bus_err_q;
  // The downstream register advances only when an instruction is delivered,
  // or when no fetch is being requested.
  assign fetch_busy = (state_q != IDLE) | (fetch_en & ~insn_valid_q);

endmodule
